// File: rtl/multi_user_auth_pkg.sv
// ---------------------------------------------------------------------------
// multi_user_auth_pkg
// Shared types and constants for the multi-user login front-end:
//   - auth_state_t   : login state machine states
//   - NUM_USERS      : number of registered users
//   - MAX_ATTEMPTS   : consecutive password failures before falling back to
//                      ID entry (only used with MULTI_USER_AUTH_ATTEMPT_LIMIT_EN)
//   - NO_USER        : Internal_ID value while nobody is logged in
//   - USER_ID_TABLE / USER_PW_TABLE : 4-digit BCD IDs and passwords
//   - lookup_user()  : maps a BCD ID to its table index
// ---------------------------------------------------------------------------
package multi_user_auth_pkg;

  typedef enum logic [2:0] {
    ID_ENTRY,
    ID_CHECK,
    PW_ENTRY,
    PW_CHECK,
    LOGGED_IN
  } auth_state_t;

  localparam int NUM_USERS    = 4;
  localparam int MAX_ATTEMPTS = 3;

  localparam logic [4:0] NO_USER = 5'h1F;

  localparam logic [15:0] USER_ID_TABLE [NUM_USERS] = '{
    16'h4456, 16'h3699, 16'h1234, 16'h9876
  };

  localparam logic [15:0] USER_PW_TABLE [NUM_USERS] = '{
    16'h2468, 16'h1357, 16'h0000, 16'h5432
  };

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } user_lookup_t;

  // Registered IDs are unique, so the scan order only matters for style.
  function automatic user_lookup_t lookup_user(input logic [15:0] id);
    user_lookup_t result;
    result = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      if (id == USER_ID_TABLE[i]) begin
        result.found = 1'b1;
        result.idx   = 2'(i);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/auth_digit_collector.sv
// ---------------------------------------------------------------------------
// auth_digit_collector
// Collects 4 BCD digits from the keypad, one per rising edge of game_enter,
// most-significant digit first.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   game_enter   : keypad strobe (level; rising edge enters a digit)
//   user_digit   : BCD digit sampled with the strobe
//   enable       : digits are accepted only while high
//   clear        : empties the shift register and poison flag
//   digits       : collected 4-digit BCD value
//   invalid      : a non-BCD digit (>9) was entered into the current entry
//   done         : combinational; high in the cycle the 4th digit is taken
// ---------------------------------------------------------------------------
module auth_digit_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enter,
  input  logic [3:0]  user_digit,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        invalid,
  output logic        done
);

  logic        enter_prev;
  logic [1:0]  digit_cnt;
  logic [15:0] shift_reg;
  logic        invalid_q;
  logic        take;

  // The previous strobe value is tracked even while disabled, so an edge
  // that arrives during a check is consumed rather than replayed later.
  assign take    = game_enter & ~enter_prev & enable;
  assign done    = take & (digit_cnt == 2'd3);
  assign digits  = shift_reg;
  assign invalid = invalid_q;

  // The digit counter wraps to 0 on the 4th digit; the shift register and
  // poison flag stay intact until the FSM has evaluated them and clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_prev <= 1'b0;
      digit_cnt  <= 2'd0;
      shift_reg  <= 16'h0000;
      invalid_q  <= 1'b0;
    end else begin
      enter_prev <= game_enter;
      if (clear) begin
        digit_cnt <= 2'd0;
        shift_reg <= 16'h0000;
        invalid_q <= 1'b0;
      end else if (take) begin
        digit_cnt <= digit_cnt + 2'd1;
        shift_reg <= {shift_reg[11:0], user_digit};
        if (user_digit > 4'd9) begin
          invalid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_user_auth.sv
// ---------------------------------------------------------------------------
// multi_user_auth
// Login front-end: a 4-digit user ID followed by a 4-digit password, checked
// against the user table in multi_user_auth_pkg.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   Game_Enter   : keypad digit strobe (rising-edge detected)
//   User_digit   : BCD digit
//   GCLogOut     : logout request from the game controller
//   LogIn        : high while a user is logged in
//   LogOut       : one-cycle pulse when a session ends
//   Internal_ID  : logged-in user's table index, NO_USER otherwise
// Configuration macro:
//   MULTI_USER_AUTH_ATTEMPT_LIMIT_EN : when defined, 3 consecutive password
//   failures return to ID entry; otherwise the user may retry forever.
// ---------------------------------------------------------------------------
module multi_user_auth
  import multi_user_auth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Game_Enter,
  input  logic [3:0] User_digit,
  input  logic       GCLogOut,
  output logic       LogIn,
  output logic       LogOut,
  output logic [4:0] Internal_ID
);

  auth_state_t  state, next_state;
  logic [1:0]   user_idx, next_user_idx;
  logic         logout_q, next_logout;
  logic         collect_en, collect_clr;
  logic [15:0]  digits;
  logic         invalid;
  logic         done;
  user_lookup_t lookup;

`ifdef MULTI_USER_AUTH_ATTEMPT_LIMIT_EN
  logic [1:0]   attempts, next_attempts;
`endif

  auth_digit_collector u_collector (
    .clk        (clk),
    .rst        (rst),
    .game_enter (Game_Enter),
    .user_digit (User_digit),
    .enable     (collect_en),
    .clear      (collect_clr),
    .digits     (digits),
    .invalid    (invalid),
    .done       (done)
  );

  assign lookup = lookup_user(digits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ID_ENTRY;
      user_idx <= 2'd0;
      logout_q <= 1'b0;
    end else begin
      state    <= next_state;
      user_idx <= next_user_idx;
      logout_q <= next_logout;
    end
  end

`ifdef MULTI_USER_AUTH_ATTEMPT_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempts <= 2'd0;
    end else begin
      attempts <= next_attempts;
    end
  end
`endif

  // Both check states clear the collector: whether the entry matched or
  // not, the next phase starts from an empty, unpoisoned register.
  always_comb begin
    next_state    = state;
    next_user_idx = user_idx;
    next_logout   = 1'b0;
    collect_en    = 1'b0;
    collect_clr   = 1'b0;
`ifdef MULTI_USER_AUTH_ATTEMPT_LIMIT_EN
    next_attempts = attempts;
`endif
    case (state)
      ID_ENTRY: begin
        collect_en = 1'b1;
        if (done) begin
          next_state = ID_CHECK;
        end
      end
      ID_CHECK: begin
        collect_clr = 1'b1;
        if (lookup.found && !invalid) begin
          next_state    = PW_ENTRY;
          next_user_idx = lookup.idx;
`ifdef MULTI_USER_AUTH_ATTEMPT_LIMIT_EN
          next_attempts = 2'd0;
`endif
        end else begin
          next_state = ID_ENTRY;
        end
      end
      PW_ENTRY: begin
        collect_en = 1'b1;
        if (done) begin
          next_state = PW_CHECK;
        end
      end
      PW_CHECK: begin
        collect_clr = 1'b1;
        if (!invalid && (digits == USER_PW_TABLE[user_idx])) begin
          next_state = LOGGED_IN;
        end else begin
`ifdef MULTI_USER_AUTH_ATTEMPT_LIMIT_EN
          if ((attempts + 2'd1) == 2'(MAX_ATTEMPTS)) begin
            next_attempts = 2'd0;
            next_state    = ID_ENTRY;
          end else begin
            next_attempts = attempts + 2'd1;
            next_state    = PW_ENTRY;
          end
`else
          next_state = PW_ENTRY;
`endif
        end
      end
      LOGGED_IN: begin
        // Leaving LOGGED_IN on the first sampled request guarantees a single
        // pulse even if GCLogOut is held high.
        if (GCLogOut) begin
          next_logout = 1'b1;
          next_state  = ID_ENTRY;
        end
      end
      default: begin
        next_state = ID_ENTRY;
      end
    endcase
  end

  assign LogIn       = (state == LOGGED_IN);
  assign LogOut      = logout_q;
  assign Internal_ID = LogIn ? {3'b000, user_idx} : NO_USER;

endmodule

// File: tb/tb_multi_user_auth.sv
// ---------------------------------------------------------------------------
// tb_multi_user_auth
// Self-checking bench for multi_user_auth. A session-level reference model
// (decimal ID/password tables, a queue of typed digits, a failure count)
// predicts LogIn / LogOut / Internal_ID after every clock edge.
// Honours MULTI_USER_AUTH_ATTEMPT_LIMIT_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_user_auth;

  logic       clk;
  logic       rst;
  logic       Game_Enter;
  logic [3:0] User_digit;
  logic       GCLogOut;
  logic       LogIn;
  logic       LogOut;
  logic [4:0] Internal_ID;

  int checks   = 0;
  int failures = 0;

`ifdef MULTI_USER_AUTH_ATTEMPT_LIMIT_EN
  localparam bit ATTEMPT_LIMIT = 1'b1;
`else
  localparam bit ATTEMPT_LIMIT = 1'b0;
`endif

  multi_user_auth dut (
    .clk         (clk),
    .rst         (rst),
    .Game_Enter  (Game_Enter),
    .User_digit  (User_digit),
    .GCLogOut    (GCLogOut),
    .LogIn       (LogIn),
    .LogOut      (LogOut),
    .Internal_ID (Internal_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = typing ID, 1 = typing password, 2 = logged in.
  int ref_ids [4] = '{4456, 3699, 1234, 9876};
  int ref_pws [4] = '{2468, 1357, 0, 5432};
  int m_mode;
  int m_user;
  int m_fails;
  int m_entry[$];
  bit m_pending;
  bit m_prev_ge;
  bit m_logout;

  function automatic void model_reset();
    m_mode    = 0;
    m_user    = 0;
    m_fails   = 0;
    m_entry.delete();
    m_pending = 1'b0;
    m_prev_ge = 1'b0;
    m_logout  = 1'b0;
  endfunction

  function automatic void model_resolve();
    bit poisoned;
    int value;
    int hit;
    poisoned = 1'b0;
    value    = 0;
    foreach (m_entry[i]) begin
      if (m_entry[i] > 9) poisoned = 1'b1;
      value = value * 10 + m_entry[i];
    end
    m_entry.delete();
    if (m_mode == 0) begin
      hit = -1;
      for (int u = 0; u < 4; u++) if (!poisoned && value == ref_ids[u]) hit = u;
      if (hit >= 0) begin
        m_mode  = 1;
        m_user  = hit;
        m_fails = 0;
      end
    end else begin
      if (!poisoned && value == ref_pws[m_user]) begin
        m_mode = 2;
      end else begin
        m_fails++;
        if (ATTEMPT_LIMIT && m_fails >= 3) begin
          m_fails = 0;
          m_mode  = 0;
        end
      end
    end
  endfunction

  // One clock edge worth of behaviour, given the inputs present at the edge.
  function automatic void model_edge(input bit ge, input int dig, input bit gclo);
    m_logout = 1'b0;
    if (m_pending) begin
      m_pending = 1'b0;
      model_resolve();
    end else if (m_mode == 2) begin
      if (gclo) begin
        m_logout = 1'b1;
        m_mode   = 0;
      end
    end else if (ge && !m_prev_ge) begin
      m_entry.push_back(dig);
      if (m_entry.size() == 4) m_pending = 1'b1;
    end
    m_prev_ge = ge;
  endfunction

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_against_model(input string tag);
    check_output({tag, ".LogIn"}, {7'd0, LogIn}, {7'd0, m_mode == 2});
    check_output({tag, ".LogOut"}, {7'd0, LogOut}, {7'd0, m_logout});
    check_output({tag, ".Internal_ID"}, {3'd0, Internal_ID},
                 (m_mode == 2) ? 8'(m_user) : 8'h1F);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(Game_Enter, int'(User_digit), GCLogOut);
    #1;
    check_against_model(tag);
  endtask

  task automatic press(input int d, input int hold, input string tag);
    Game_Enter = 1'b1;
    User_digit = 4'(d);
    repeat (hold) tick(tag);
    Game_Enter = 1'b0;
    tick(tag);
  endtask

  task automatic enter_num(input int n, input string tag);
    press((n / 1000) % 10, 1, tag);
    press((n / 100) % 10, 1, tag);
    press((n / 10) % 10, 1, tag);
    press(n % 10, 1, tag);
  endtask

  task automatic logout(input int hold, input string tag);
    GCLogOut = 1'b1;
    repeat (hold) tick(tag);
    GCLogOut = 1'b0;
    tick(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_output({tag, ".rst_LogIn"}, {7'd0, LogIn}, 8'd0);
    check_output({tag, ".rst_LogOut"}, {7'd0, LogOut}, 8'd0);
    check_output({tag, ".rst_ID"}, {3'd0, Internal_ID}, 8'h1F);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(tag);
  endtask

  initial begin
    int pulses;
    rst        = 1'b1;
    Game_Enter = 1'b0;
    User_digit = 4'd0;
    GCLogOut   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset.LogIn", {7'd0, LogIn}, 8'd0);
    check_output("reset.LogOut", {7'd0, LogOut}, 8'd0);
    check_output("reset.Internal_ID", {3'd0, Internal_ID}, 8'h1F);
    rst = 1'b0;
    tick("post_reset");

    // Unknown ID is rejected and the block waits for a new ID.
    enter_num(1699, "bad_id");

    // Three wrong passwords for a valid ID, then a full valid login.
    enter_num(4456, "id0");
    repeat (3) enter_num(1357, "pw_fail");
    enter_num(3699, "after_fails");
    enter_num(1357, "after_fails");
    check_output("after_fails.login", {7'd0, LogIn}, {7'd0, ATTEMPT_LIMIT});
    apply_reset("reset2");

    // Login timing: LogIn must rise one edge after the 4th digit capture.
    enter_num(3699, "id1");
    press(1, 1, "pw1");
    press(3, 1, "pw1");
    press(5, 1, "pw1");
    Game_Enter = 1'b1;
    User_digit = 4'd7;
    tick("pw1_last");
    check_output("login_edgeN", {7'd0, LogIn}, 8'd0);
    Game_Enter = 1'b0;
    tick("pw1_check");
    check_output("login_edgeN1", {7'd0, LogIn}, 8'd1);
    check_output("login_id", {3'd0, Internal_ID}, 8'd1);

    // Digits while logged in are ignored; held logout gives one pulse.
    press(4, 1, "ignored_digit");
    pulses     = 0;
    GCLogOut   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("logout_hold");
      if (LogOut) pulses++;
    end
    GCLogOut = 1'b0;
    tick("logout_release");
    check_output("logout_pulses", 8'(pulses), 8'd1);
    check_output("logout_id", {3'd0, Internal_ID}, 8'h1F);

    // A held strobe enters one digit only.
    press(4, 5, "held_digit");
    press(4, 1, "id0b");
    press(5, 1, "id0b");
    press(6, 1, "id0b");
    enter_num(2468, "pw0");
    check_output("held_login", {7'd0, LogIn}, 8'd1);
    logout(2, "logout2");

    // Non-BCD digit poisons the ID.
    press(1, 1, "poison");
    press(2, 1, "poison");
    press(12, 1, "poison");
    press(4, 1, "poison");
    check_output("poison_login", {7'd0, LogIn}, 8'd0);

    // Reset in the middle of password entry.
    enter_num(9876, "id3");
    press(5, 1, "pw3_part");
    press(4, 1, "pw3_part");
    apply_reset("mid_pw_reset");

    // Five wrong passwords, then the right one.
    enter_num(1234, "id2");
    repeat (5) enter_num(1111, "pw2_fail");
    enter_num(0, "pw2_ok");
    check_output("five_fails.login", {7'd0, LogIn}, {7'd0, !ATTEMPT_LIMIT});
    apply_reset("reset3");

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      int u;
      int idv;
      int pwv;
      u   = int'($urandom_range(0, 3));
      idv = ($urandom_range(0, 3) != 0) ? ref_ids[u] : int'($urandom_range(0, 9999));
      for (int k = 0; k < 4; k++) begin
        int d;
        d = (idv / (k == 0 ? 1000 : k == 1 ? 100 : k == 2 ? 10 : 1)) % 10;
        if ($urandom_range(0, 19) == 0) d = int'($urandom_range(10, 15));
        press(d, int'($urandom_range(1, 3)), "rnd_id");
        repeat ($urandom_range(0, 2)) tick("rnd_idle");
      end
      pwv = ($urandom_range(0, 1) != 0) ? ref_pws[u] : int'($urandom_range(0, 9999));
      enter_num(pwv, "rnd_pw");
      if ($urandom_range(0, 3) == 0) press(int'($urandom_range(0, 9)), 1, "rnd_extra");
      if ($urandom_range(0, 1) != 0) logout(int'($urandom_range(1, 4)), "rnd_logout");
      if ($urandom_range(0, 7) == 0) apply_reset("rnd_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
